// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg: shared matrix-mult constants, job descriptor and output-writer helpers
package matrix_mult_pkg;
    localparam int WIDTH = 8;
    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int O_SIZE = 512;
    localparam int OUT_WIDTH = 2 * WIDTH + $clog2(ROW);
    localparam int OUT_DATA_WIDTH = COL * OUT_WIDTH;
    localparam int ADDR_W = $clog2(O_SIZE);
    localparam int ROWS_W = 16;

    typedef enum logic [1:0] {WR_IDLE, WR_COLLECT, WR_FINISH} wr_state_t;

    typedef struct packed {
        logic [ROWS_W-1:0] i_rows;
        logic [7:0]        w_cols;
        logic [ADDR_W-1:0] psum_offset;
        logic [ADDR_W-1:0] o_offset_w;
        logic              accum_en;
    } data_config_struct;

    // w_cols of 0 or beyond COL enables every lane
    function automatic logic [COL-1:0] col_mask(input logic [7:0] w);
        logic [COL-1:0] m;
        for (int c = 0; c < COL; c++)
            m[c] = (w == 8'd0) || (int'(w) > COL) || (c < int'(w));
        return m;
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base, input logic [ROWS_W-1:0] r);
        logic [ROWS_W:0] s;
        s = (ROWS_W+1)'(base) + (ROWS_W+1)'(r);
        return ADDR_W'(s % (ROWS_W+1)'(O_SIZE));
    endfunction

    function automatic logic [OUT_DATA_WIDTH-1:0] lane_add(input logic [OUT_DATA_WIDTH-1:0] a, input logic [OUT_DATA_WIDTH-1:0] b);
        logic [OUT_DATA_WIDTH-1:0] y;
        for (int c = 0; c < COL; c++)
            y[c*OUT_WIDTH +: OUT_WIDTH] = a[c*OUT_WIDTH +: OUT_WIDTH] + b[c*OUT_WIDTH +: OUT_WIDTH];
        return y;
    endfunction
endpackage

// File: rtl/matrix_mult_deskew.sv
// matrix_mult_deskew: fixed-depth register delay for one array column (data and valid)
module matrix_mult_deskew #(
    parameter int DEPTH = 1,
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic [DEPTH-1:0] v;
    logic [W-1:0]     d [DEPTH];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid;
            d[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end

    assign out_valid = v[DEPTH-1];
    assign out_data = d[DEPTH-1];
endmodule

// File: rtl/matrix_mult_out_writer.sv
// matrix_mult_out_writer: deskews array column results into rows, optionally adds
// a partial-sum row, and writes each row to output memory
import matrix_mult_pkg::*;

module matrix_mult_out_writer (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  data_config_struct         cfg,
    input  logic [COL-1:0]            arr_valid,
    input  logic [OUT_DATA_WIDTH-1:0] arr_data,
    output logic                      psum_rd_en,
    output logic [ADDR_W-1:0]         psum_rd_addr,
    input  logic [OUT_DATA_WIDTH-1:0] psum_rd_data,
    output logic                      o_wr_en,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic [OUT_DATA_WIDTH-1:0] o_wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      skew_err
);
    wr_state_t                 state, state_n;
    data_config_struct         job;
    logic [ROWS_W-1:0]         iss_cnt, wr_cnt;
    logic [COL-1:0]            dv, lane_m;
    logic [OUT_DATA_WIDTH-1:0] dd, masked, s1_data;
    logic                      accept;

    // column c lags column 0 by c cycles, so it needs COL-1-c stages to line up
    for (genvar c = 0; c < COL; c++) begin : g_col
        if (c == COL - 1) begin : g_direct
            assign dv[c] = arr_valid[c];
            assign dd[c*OUT_WIDTH +: OUT_WIDTH] = arr_data[c*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_delay
            matrix_mult_deskew #(.DEPTH(COL - 1 - c), .W(OUT_WIDTH)) u_deskew (
                .clk(clk),
                .rst(rst),
                .in_valid(arr_valid[c]),
                .in_data(arr_data[c*OUT_WIDTH +: OUT_WIDTH]),
                .out_valid(dv[c]),
                .out_data(dd[c*OUT_WIDTH +: OUT_WIDTH])
            );
        end
    end

    assign lane_m = col_mask(job.w_cols);
    assign accept = (state == WR_COLLECT) && dv[0] && (iss_cnt < job.i_rows);
    assign skew_err = (state == WR_COLLECT) && dv[0] && |((dv ^ {COL{dv[0]}}) & lane_m);
    assign psum_rd_en = accept && job.accum_en;
    assign psum_rd_addr = psum_rd_en ? wrap_addr(job.psum_offset, iss_cnt) : '0;
    assign o_wr_data = !o_wr_en ? '0 : job.accum_en ? lane_add(s1_data, psum_rd_data) : s1_data;
    assign busy = state == WR_COLLECT;
    assign done = state == WR_FINISH;

    always_comb begin
        masked = '0;
        for (int c = 0; c < COL; c++)
            masked[c*OUT_WIDTH +: OUT_WIDTH] = lane_m[c] ? dd[c*OUT_WIDTH +: OUT_WIDTH] : '0;
    end

    always_comb begin
        state_n = state;
        case (state)
            WR_IDLE:    if (start) state_n = (cfg.i_rows == '0) ? WR_FINISH : WR_COLLECT;
            WR_COLLECT: if (o_wr_en && (wr_cnt + ROWS_W'(1)) == job.i_rows) state_n = WR_FINISH;
            default:    state_n = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= WR_IDLE;
            job <= '0;
            iss_cnt <= '0;
            wr_cnt <= '0;
            o_wr_en <= 1'b0;
            o_wr_addr <= '0;
            s1_data <= '0;
        end else begin
            state <= state_n;
            if (state == WR_IDLE && start) begin
                job <= cfg;
                iss_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                iss_cnt <= iss_cnt + ROWS_W'(accept);
                wr_cnt <= wr_cnt + ROWS_W'(o_wr_en);
            end
            o_wr_en <= accept;
            o_wr_addr <= accept ? wrap_addr(job.o_offset_w, iss_cnt) : '0;
            s1_data <= accept ? masked : '0;
        end
endmodule
